// File: rtl/counter_load_sched_pkg.sv
// Shared types for the counter load scheduler: FSM state encoding and owner ids.
// No logic, no latency.
// No flow control.
package counter_load_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/counter_load_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins; on contention the one that did not win last time wins.
// Combinational, zero latency.
// No backpressure; grant is purely advisory until the caller registers it.
module rr_arb2
  import counter_load_sched_pkg::*;
(
  input  logic       last_owner,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // bit 0 = A, bit 1 = B; on a tie the previous loser is favoured
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | (last_owner == OWNER_B));
    grant[1] = req[1] & (~req[0] | (last_owner == OWNER_A));
  end

endmodule

// File: rtl/counter_up_load.sv
// Loadable up counter, wraps at 2^WIDTH-1 -> 0; load has priority over counting.
// Load value appears on count the cycle after the load strobe.
// No backpressure; counts every cycle.
module counter_up_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);

  // synchronous load, otherwise increment with natural wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else if (load) count <= data;
    else count <= count + 1'b1;
  end

endmodule

// File: rtl/counter_load_sched.sv
// Schedules one shared loadable counter between requesters A and B; loads the winner's start value, pulses done at TERM.
// ack -> done latency is (TERM-start) mod 2^WIDTH + 3 cycles; all outputs registered.
// Requests held while busy wait for the next IDLE cycle; abort cancels LOAD/RUN. Option: COUNTER_LOAD_SCHED_PERIODIC_EN.
module counter_load_sched
  import counter_load_sched_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TERM  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  output logic             done_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             done_b,
  input  logic             abort,
`ifdef COUNTER_LOAD_SCHED_PERIODIC_EN
  input  logic             periodic,
`endif
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             busy,
  output logic             owner
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q;
  logic             owner_q;
  logic             last_owner_q;
  logic [1:0]       grant;
  logic             granted;
  logic             rerun;

  logic             ack_a_q, ack_b_q, done_a_q, done_b_q, cnt_load_q;
  logic             ack_a_d, ack_b_d, done_a_d, done_b_d, cnt_load_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;

  rr_arb2 u_arb (
    .last_owner (last_owner_q),
    .req        ({req_b, req_a}),
    .grant      (grant)
  );

  assign granted = (state_q == ST_IDLE) && (grant != 2'b00);

`ifdef COUNTER_LOAD_SCHED_PERIODIC_EN
  logic periodic_q;

  // periodic flag is captured with the grant and lives for the whole job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) periodic_q <= 1'b0;
    else if (granted) periodic_q <= periodic;
  end

  assign rerun = periodic_q;
`else
  assign rerun = 1'b0;
`endif

  // state register plus per-job context captured on the grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      start_q      <= '0;
      owner_q      <= OWNER_A;
      last_owner_q <= OWNER_B;
    end else begin
      state_q <= state_d;
      if (granted) begin
        start_q      <= grant[1] ? data_b : data_a;
        owner_q      <= grant[1] ? OWNER_B : OWNER_A;
        last_owner_q <= grant[1] ? OWNER_B : OWNER_A;
      end
    end
  end

  // next state: abort beats the terminal-count hit, but cannot cancel DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (granted) state_d = ST_LOAD;
      ST_LOAD: state_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) state_d = ST_IDLE;
        else if (cnt_count == TERM) state_d = ST_DONE;
      end
      ST_DONE: state_d = rerun ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // next values of the registered outputs; done is decoded from DONE and shows one cycle later
  always_comb begin
    ack_a_d    = granted & grant[0];
    ack_b_d    = granted & grant[1];
    done_a_d   = (state_q == ST_DONE) && (owner_q == OWNER_A);
    done_b_d   = (state_q == ST_DONE) && (owner_q == OWNER_B);
    cnt_load_d = (state_d == ST_LOAD);
    cnt_data_d = cnt_data_q;
    if (granted) cnt_data_d = grant[1] ? data_b : data_a;
    else if ((state_q == ST_DONE) && rerun) cnt_data_d = start_q;
  end

  // output registers; cnt_data holds its last load value between jobs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_data_q <= '0;
    end else begin
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
      cnt_load_q <= cnt_load_d;
      cnt_data_q <= cnt_data_d;
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign done_a   = done_a_q;
  assign done_b   = done_b_q;
  assign cnt_load = cnt_load_q;
  assign cnt_data = cnt_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_counter_load_sched.sv
// Directed bench for counter_load_sched driving a real counter_up_load.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// COUNTER_LOAD_SCHED_PERIODIC_EN enables the periodic-job scenario.
module tb_counter_load_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, abort, periodic;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, done_a, done_b, cnt_load, busy, owner;
  logic [7:0] cnt_data, cnt_count;

  int errors = 0;
  int checks = 0;
  int n, stray, cnt;

  always #5 clk = ~clk;

  counter_load_sched #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .done_a    (done_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .done_b    (done_b),
    .abort     (abort),
`ifdef COUNTER_LOAD_SCHED_PERIODIC_EN
    .periodic  (periodic),
`endif
    .cnt_load  (cnt_load),
    .cnt_data  (cnt_data),
    .cnt_count (cnt_count),
    .busy      (busy),
    .owner     (owner)
  );

  counter_up_load #(.WIDTH(8)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .data  (cnt_data),
    .count (cnt_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycles until the selected done pulse (-1 on timeout); stray counts acks or the other side's done meanwhile
  task automatic wait_done(input bit is_b, input int max, output int cycles, output int other);
    bit hit;
    hit    = 1'b0;
    cycles = 0;
    other  = 0;
    while (!hit && cycles < max) begin
      tick();
      cycles++;
      if (is_b ? done_b : done_a) hit = 1'b1;
      else if (ack_a || ack_b || (is_b ? done_a : done_b)) other++;
    end
    if (!hit) cycles = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; abort = 1'b0; periodic = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    #3;
    check("rst_busy", busy, 0);
    check("rst_ack", {ack_a, ack_b}, 0);
    check("rst_done", {done_a, done_b}, 0);
    check("rst_load", cnt_load, 0);
    check("rst_data", cnt_data, 0);
    check("rst_owner", owner, 0);
    tick();
    rst = 1'b1;

    // 1: single A job from FA: done 8 cycles after ack
    req_a = 1'b1; data_a = 8'hFA;
    tick();
    check("t1_ack", ack_a, 1);
    check("t1_load", cnt_load, 1);
    check("t1_data", cnt_data, 8'hFA);
    check("t1_busy", busy, 1);
    req_a = 1'b0;
    tick();
    check("t1_ack_1cyc", ack_a, 0);
    check("t1_load_1cyc", cnt_load, 0);
    wait_done(1'b0, 20, n, stray);
    check("t1_lat", n + 1, 8);
    check("t1_busy_after", busy, 0);
    tick();
    check("t1_done_1cyc", done_a, 0);

    // 2: contest straight out of reset: A first, then B on the IDLE after A's done
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1; data_a = 8'hFE; data_b = 8'hFF;
    tick();
    check("t2_ack_a", ack_a, 1);
    check("t2_ack_b", ack_b, 0);
    check("t2_owner", owner, 0);
    req_a = 1'b0;
    wait_done(1'b0, 20, n, stray);
    check("t2_lat_a", n, 4);
    check("t2_stray_a", stray, 0);
    check("t2_no_ack_b_at_done", ack_b, 0);
    tick();
    check("t2_ack_b_next", ack_b, 1);
    check("t2_owner_b", owner, 1);
    req_b = 1'b0;

    // 3: start FF -> 3 cycles; start 00 -> 258 cycles with A waiting throughout
    wait_done(1'b1, 20, n, stray);
    check("t3_lat_ff", n, 3);
    req_b = 1'b1; data_b = 8'h00;
    tick();
    check("t3_ack_b", ack_b, 1);
    req_b = 1'b0; req_a = 1'b1; data_a = 8'hFF;
    wait_done(1'b1, 300, n, stray);
    check("t3_lat_00", n, 258);
    check("t3_stray", stray, 0);
    tick();
    check("t3_ack_a_after", ack_a, 1);
    req_a = 1'b0;
    wait_done(1'b0, 20, n, stray);
    check("t3_lat_a", n, 3);

    // 4: abort 4 cycles after ack of a 10 job; B pending then gets the counter
    req_a = 1'b1; data_a = 8'h10;
    tick();
    check("t4_ack_a", ack_a, 1);
    req_a = 1'b0; req_b = 1'b1; data_b = 8'hFF;
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_idle", busy, 0);
    check("t4_no_ack_b_yet", ack_b, 0);
    tick();
    check("t4_ack_b", ack_b, 1);
    check("t4_owner", owner, 1);
    req_b = 1'b0;
    wait_done(1'b1, 20, n, stray);
    check("t4_lat_b", n, 3);
    check("t4_no_done_a", stray, 0);

    // abort in the same RUN cycle as the TERM hit suppresses done
    req_a = 1'b1; data_a = 8'hFF;
    tick();
    req_a = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_hit_idle", busy, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_a) cnt++;
    end
    check("t4_abort_hit_nodone", cnt, 0);

    // abort during DONE is ignored
    req_a = 1'b1; data_a = 8'hFF;
    tick();
    req_a = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_in_done", done_a, 1);

    // 5: reset mid-RUN of a B job drops everything; B alone is acked afterwards
    req_b = 1'b1; data_b = 8'h00;
    tick();
    check("t5_ack_b", ack_b, 1);
    req_b = 1'b0;
    repeat (5) tick();
    check("t5_busy_run", busy, 1);
    rst = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_owner", owner, 0);
    check("t5_pulses", {ack_a, ack_b, done_a, done_b, cnt_load}, 0);
    check("t5_data", cnt_data, 0);
    tick();
    rst = 1'b1;
    req_b = 1'b1; data_b = 8'hFF;
    tick();
    check("t5_ack_b_after", ack_b, 1);
    check("t5_owner_b", owner, 1);
    req_b = 1'b0;
    wait_done(1'b1, 20, n, stray);
    check("t5_lat_b", n, 3);

`ifdef COUNTER_LOAD_SCHED_PERIODIC_EN
    // 6: periodic A job from FC repeats every 6 cycles and starves B until abort
    req_a = 1'b1; data_a = 8'hFC; periodic = 1'b1;
    tick();
    check("t6_ack_a", ack_a, 1);
    req_a = 1'b0; periodic = 1'b0; req_b = 1'b1; data_b = 8'hFF;
    wait_done(1'b0, 20, n, stray);
    check("t6_period1", n, 6);
    check("t6_stray1", stray, 0);
    wait_done(1'b0, 20, n, stray);
    check("t6_period2", n, 6);
    check("t6_stray2", stray, 0);
    check("t6_reload", cnt_load, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_idle", busy, 0);
    check("t6_no_ack_b_yet", ack_b, 0);
    tick();
    check("t6_ack_b", ack_b, 1);
    req_b = 1'b0;
    wait_done(1'b1, 20, n, stray);
    check("t6_lat_b", n, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
